// File: rtl/vga_board_display.sv
// rtl/vga_board_display.sv - VGA raster timing plus pipelined GRID_N x GRID_N board renderer
// Stage 0 counters, stage 1 decode, stage 2 colour/sync registers; board inputs shadowed once per frame.
module vga_board_display #(
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int GRID_N       = 5,
  parameter int CELL_PX      = 64,
  parameter int ORIGIN_X     = 160,
  parameter int ORIGIN_Y     = 80,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [2*GRID_N*GRID_N-1:0]   cells,
  input  logic [3:0]                   cursor_x,
  input  logic [3:0]                   cursor_y,
  input  logic                         cursor_en,
  input  logic                         overlay_lose,
  output logic                         hsync,
  output logic                         vsync,
  output logic                         sync_b,
  output logic                         blank_b,
  output logic [7:0]                   r,
  output logic [7:0]                   g,
  output logic [7:0]                   b,
  output logic                         frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int SW      = $clog2(CELL_PX);
  localparam int CW      = 5;
  localparam int NCELL   = GRID_N * GRID_N;
  localparam int BW      = $clog2(BLINK_FRAMES + 1);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [HW-1:0] X_BEG    = HW'(ORIGIN_X);
  localparam logic [HW-1:0] X_LAST   = HW'(ORIGIN_X + GRID_N * CELL_PX - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [VW-1:0] Y_BEG    = VW'(ORIGIN_Y);
  localparam logic [VW-1:0] Y_LAST   = VW'(ORIGIN_Y + GRID_N * CELL_PX - 1);
  localparam logic [SW-1:0] SUB_LAST = SW'(CELL_PX - 1);
  localparam logic [SW-1:0] SUB_HI   = SW'(CELL_PX - 2);
  localparam logic [CW-1:0] GRID_C   = CW'(GRID_N);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  // Stage 0: raster counters with incremental cell column/row tracking
  logic [HW-1:0] r_hcnt;
  logic [VW-1:0] r_vcnt;
  logic [SW-1:0] r_hsub, r_vsub;
  logic [CW-1:0] r_hcol, r_vrow;
  logic          w_h_last, w_v_last;
  logic [HW-1:0] w_hcnt_nxt;
  logic [VW-1:0] w_vcnt_nxt;

  assign w_h_last   = (r_hcnt == H_LAST);
  assign w_v_last   = (r_vcnt == V_LAST);
  assign w_hcnt_nxt = w_h_last ? '0 : r_hcnt + HW'(1);
  assign w_vcnt_nxt = w_v_last ? '0 : r_vcnt + VW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
      r_hsub <= '0;
      r_hcol <= '0;
      r_vsub <= '0;
      r_vrow <= '0;
    end else begin
      r_hcnt <= w_hcnt_nxt;
      if (w_hcnt_nxt == X_BEG) begin
        r_hsub <= '0;
        r_hcol <= '0;
      end else if (r_hsub == SUB_LAST) begin
        r_hsub <= '0;
        r_hcol <= r_hcol + CW'(1);
      end else begin
        r_hsub <= r_hsub + SW'(1);
      end
      if (w_h_last) begin
        r_vcnt <= w_vcnt_nxt;
        if (w_vcnt_nxt == Y_BEG) begin
          r_vsub <= '0;
          r_vrow <= '0;
        end else if (r_vsub == SUB_LAST) begin
          r_vsub <= '0;
          r_vrow <= r_vrow + CW'(1);
        end else begin
          r_vsub <= r_vsub + SW'(1);
        end
      end
    end
  end

  // Shadow capture at the start of vertical blank keeps a frame tear-free
  logic [2*NCELL-1:0] r_sh_cells;
  logic [3:0]         r_sh_cx, r_sh_cy;
  logic               r_sh_cen, r_sh_lose;
  logic [BW-1:0]      r_blink_cnt;
  logic               r_blink_on;
  logic               w_capture;

  assign w_capture = (r_hcnt == '0) && (r_vcnt == V_ACT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh_cells  <= '0;
      r_sh_cx     <= '0;
      r_sh_cy     <= '0;
      r_sh_cen    <= 1'b0;
      r_sh_lose   <= 1'b0;
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else if (w_capture) begin
      r_sh_cells <= cells;
      r_sh_cx    <= cursor_x;
      r_sh_cy    <= cursor_y;
      r_sh_cen   <= cursor_en;
      r_sh_lose  <= overlay_lose;
      if (r_blink_cnt == BLINK_LAST) begin
        r_blink_cnt <= '0;
        r_blink_on  <= ~r_blink_on;
      end else begin
        r_blink_cnt <= r_blink_cnt + BW'(1);
      end
    end
  end

  // Stage 1: cell decode, cursor hit and sync/blank
  logic       w_in_board, w_cur_vis, w_cur_cell, w_border;
  logic [8:0] w_idx;
  logic [1:0] w_state;

  assign w_in_board = (r_hcnt >= X_BEG) && (r_hcnt <= X_LAST) &&
                      (r_vcnt >= Y_BEG) && (r_vcnt <= Y_LAST);
  assign w_idx      = w_in_board ? (9'(r_vrow) * 9'(GRID_N) + 9'(r_hcol)) : 9'd0;
  assign w_cur_vis  = r_sh_cen && r_blink_on &&
                      ({1'b0, r_sh_cx} < GRID_C) && ({1'b0, r_sh_cy} < GRID_C);
  assign w_cur_cell = ({1'b0, r_sh_cx} == r_hcol) && ({1'b0, r_sh_cy} == r_vrow);
  assign w_border   = (r_hsub < SW'(2)) || (r_hsub >= SUB_HI) ||
                      (r_vsub < SW'(2)) || (r_vsub >= SUB_HI);

  always_comb begin
    w_state = 2'b00;
    for (int k = 0; k < NCELL; k++) begin
      if (w_idx == 9'(k)) w_state = r_sh_cells[2*k +: 2];
    end
  end

  logic       r1_hsync, r1_vsync, r1_active, r1_fs;
  logic       r1_in_board, r1_cur_hit, r1_grid;
  logic [1:0] r1_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_hsync    <= 1'b1;
      r1_vsync    <= 1'b1;
      r1_active   <= 1'b0;
      r1_fs       <= 1'b0;
      r1_in_board <= 1'b0;
      r1_cur_hit  <= 1'b0;
      r1_grid     <= 1'b0;
      r1_state    <= 2'b00;
    end else begin
      r1_hsync    <= ~((r_hcnt >= HS_FIRST) && (r_hcnt <= HS_LAST));
      r1_vsync    <= ~((r_vcnt >= VS_FIRST) && (r_vcnt <= VS_LAST));
      r1_active   <= (r_hcnt < H_ACT) && (r_vcnt < V_ACT);
      r1_fs       <= (r_hcnt == '0) && (r_vcnt == '0);
      r1_in_board <= w_in_board;
      r1_cur_hit  <= w_in_board && w_cur_vis && w_cur_cell && w_border;
      r1_grid     <= (r_hsub == '0) || (r_vsub == '0);
      r1_state    <= w_state;
    end
  end

  // Stage 2: colour priority and output registers
  logic [23:0] w_rgb;

  always_comb begin
    w_rgb = 24'h000000;
    if (!r1_active) begin
      w_rgb = 24'h000000;
    end else if (!r1_in_board) begin
      w_rgb = r_sh_lose ? 24'hFF0000 : 24'h202020;
    end else if (r1_cur_hit) begin
      w_rgb = 24'hFFFF00;
    end else if (r1_grid) begin
      w_rgb = 24'h000000;
    end else begin
      case (r1_state)
        2'b00:   w_rgb = 24'h0000FF;
        2'b01:   w_rgb = 24'h808080;
        2'b10:   w_rgb = 24'hFF0000;
        default: w_rgb = 24'hFFFFFF;
      endcase
    end
  end

  logic        r2_hsync, r2_vsync, r2_sync_b, r2_blank_b, r2_fs;
  logic [23:0] r2_rgb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r2_hsync   <= 1'b1;
      r2_vsync   <= 1'b1;
      r2_sync_b  <= 1'b1;
      r2_blank_b <= 1'b0;
      r2_fs      <= 1'b0;
      r2_rgb     <= '0;
    end else begin
      r2_hsync   <= r1_hsync;
      r2_vsync   <= r1_vsync;
      r2_sync_b  <= r1_hsync & r1_vsync;
      r2_blank_b <= r1_active;
      r2_fs      <= r1_fs;
      r2_rgb     <= w_rgb;
    end
  end

  assign hsync       = r2_hsync;
  assign vsync       = r2_vsync;
  assign sync_b      = r2_sync_b;
  assign blank_b     = r2_blank_b;
  assign frame_start = r2_fs;
  assign r           = r2_rgb[23:16];
  assign g           = r2_rgb[15:8];
  assign b           = r2_rgb[7:0];

endmodule

// File: tb/tb_vga_board_display.sv
// tb/tb_vga_board_display.sv - randomized bench for vga_board_display with a per-pixel reference model
module tb_vga_board_display;

  localparam int HA = 40, HF = 4, HS = 6, HB = 6;
  localparam int VA = 32, VF = 2, VS = 2, VB = 3;
  localparam int N = 3, C = 8, OX = 6, OY = 4, BF = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam logic [28:0] RESET_VEC = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000000};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2*N*N-1:0] cells = '0;
  logic [3:0]  cursor_x = '0, cursor_y = '0;
  logic        cursor_en = 1'b0, overlay_lose = 1'b0;
  logic        hsync, vsync, sync_b, blank_b, frame_start;
  logic [7:0]  r, g, b;

  always #5 clk = ~clk;

  vga_board_display #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .GRID_N(N), .CELL_PX(C), .ORIGIN_X(OX), .ORIGIN_Y(OY), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst(rst), .cells(cells), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .cursor_en(cursor_en), .overlay_lose(overlay_lose),
    .hsync(hsync), .vsync(vsync), .sync_b(sync_b), .blank_b(blank_b),
    .r(r), .g(g), .b(b), .frame_start(frame_start)
  );

  int n_edge;
  always @(posedge clk or posedge rst) begin
    if (rst) n_edge <= 0;
    else     n_edge <= n_edge + 1;
  end

  int n_chk = 0, n_pass = 0;

  logic [2*N*N-1:0] m_cells;
  int  m_cx, m_cy, m_bcnt;
  bit  m_cen, m_lose, m_bon;

  function automatic logic [23:0] model_rgb(int x, int y);
    int bx, by, c, rw, sx, sy, st;
    if (x >= HA || y >= VA) return 24'h000000;
    if (x < OX || x >= OX + N*C || y < OY || y >= OY + N*C)
      return m_lose ? 24'hFF0000 : 24'h202020;
    bx = x - OX; by = y - OY;
    c = bx / C; rw = by / C; sx = bx % C; sy = by % C;
    if (m_cen && m_bon && m_cx < N && m_cy < N && c == m_cx && rw == m_cy &&
        (sx < 2 || sx >= C-2 || sy < 2 || sy >= C-2))
      return 24'hFFFF00;
    if (sx == 0 || sy == 0) return 24'h000000;
    st = int'((m_cells >> (2*(rw*N + c))) & 3);
    case (st)
      0: return 24'h0000FF;
      1: return 24'h808080;
      2: return 24'hFF0000;
      default: return 24'hFFFFFF;
    endcase
  endfunction

  function automatic logic [28:0] model_vec(int x, int y);
    logic hs, vs, bl;
    hs = !(x >= HA+HF && x < HA+HF+HS);
    vs = !(y >= VA+VF && y < VA+VF+VS);
    bl = (x < HA) && (y < VA);
    return {hs, vs, hs & vs, bl, (x == 0 && y == 0), model_rgb(x, y)};
  endfunction

  logic [28:0] dut_vec;
  assign dut_vec = {hsync, vsync, sync_b, blank_b, frame_start, r, g, b};

  task automatic chk(input string nm, input logic [28:0] act, input logic [28:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  int cp_pos, cp_x, cp_y;
  always @(negedge clk) begin
    if (rst || n_edge < 2) begin
      if (rst) begin
        m_cells = '0; m_cx = 0; m_cy = 0; m_cen = 0; m_lose = 0;
        m_bcnt = 0; m_bon = 1;
      end
      chk("reset_state", dut_vec, RESET_VEC);
    end else begin
      cp_pos = (n_edge - 2) % FRAME;
      cp_x = cp_pos % HT;
      cp_y = cp_pos / HT;
      chk($sformatf("pixel x=%0d y=%0d", cp_x, cp_y), dut_vec, model_vec(cp_x, cp_y));
      if (cp_x == 0 && cp_y == VA) begin
        m_cells = cells; m_cx = int'(cursor_x); m_cy = int'(cursor_y);
        m_cen = cursor_en; m_lose = overlay_lose;
        if (m_bcnt == BF - 1) begin m_bcnt = 0; m_bon = !m_bon; end
        else m_bcnt++;
      end
    end
  end

  task automatic wait_pix(input int x, input int y, output bit ok);
    ok = 0;
    for (int i = 0; i < 3*FRAME; i++) begin
      @(posedge clk); #2;
      if (!rst && n_edge >= 2 && ((n_edge - 2) % FRAME) == y*HT + x) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_chk++;
      $display("FAIL wait_pix x=%0d y=%0d: not reached within %0d cycles", x, y, 3*FRAME);
    end
  endtask

  task automatic pix_rgb(input string nm, input int x, input int y, input logic [23:0] exp);
    bit ok;
    wait_pix(x, y, ok);
    if (ok) chk(nm, 29'({r, g, b}), 29'(exp));
  endtask

  task automatic pix_bit(input string nm, input int x, input int y, input int sel, input logic exp);
    bit ok;
    logic v;
    wait_pix(x, y, ok);
    if (ok) begin
      case (sel)
        0: v = hsync;
        1: v = vsync;
        2: v = sync_b;
        default: v = blank_b;
      endcase
      chk(nm, 29'(v), 29'(exp));
    end
  endtask

  task automatic release_and_check_start(input string nm);
    @(negedge clk); #3 rst = 1'b0;
    @(posedge clk); #2;
    chk({nm, "_fs_edge1"}, 29'(frame_start), 29'd0);
    @(posedge clk); #2;
    chk({nm, "_fs_edge2"}, 29'(frame_start), 29'd1);
    chk({nm, "_pix00"}, 29'({r, g, b}), 29'(24'h202020));
  endtask

  logic [23:0] blink_exp [5];
  bit ok;

  initial begin
    blink_exp[0] = 24'h0000FF; blink_exp[1] = 24'hFFFF00; blink_exp[2] = 24'h0000FF;
    blink_exp[3] = 24'h0000FF; blink_exp[4] = 24'hFFFF00;

    // cell (2,1) = hit, no cursor, no overlay
    cells = 18'h00800;
    repeat (3) @(posedge clk);
    release_and_check_start("rst0");

    pix_rgb("f0_hit_not_yet", 25, 15, 24'h0000FF);
    pix_rgb("f1_outside",     2,  2,  24'h202020);
    pix_rgb("f1_grid_line",   14, 4,  24'h000000);
    pix_rgb("f1_water",       9,  7,  24'h0000FF);
    pix_rgb("f1_hit",         25, 15, 24'hFF0000);
    overlay_lose = 1'b1;
    pix_rgb("f1_overlay_late", 2, 30, 24'h202020);
    pix_rgb("f2_overlay",      2, 2,  24'hFF0000);
    pix_rgb("f2_board_same",   25, 15, 24'hFF0000);

    pix_bit("hsync_43", 43, 20, 0, 1'b1);
    pix_bit("hsync_44", 44, 20, 0, 1'b0);
    pix_bit("hsync_49", 49, 20, 0, 1'b0);
    pix_bit("hsync_50", 50, 20, 0, 1'b1);
    pix_bit("blank_39", 39, 20, 3, 1'b1);
    pix_bit("blank_40", 40, 20, 3, 1'b0);
    pix_bit("vsync_33", 0, 33, 1, 1'b1);
    pix_bit("vsync_34", 0, 34, 1, 1'b0);
    pix_bit("syncb_34", 0, 34, 2, 1'b0);
    pix_bit("vsync_35", 0, 35, 1, 1'b0);
    pix_bit("vsync_36", 0, 36, 1, 1'b1);

    // asynchronous reset mid-frame
    wait_pix(20, 10, ok);
    rst = 1'b1;
    #1 chk("rst_async", dut_vec, RESET_VEC);
    cells = '0; cursor_en = 1'b1; cursor_x = 4'd0; cursor_y = 4'd0; overlay_lose = 1'b0;
    repeat (3) @(posedge clk);
    release_and_check_start("rst1");

    for (int f = 0; f < 5; f++)
      pix_rgb($sformatf("blink_f%0d", f), 7, 5, blink_exp[f]);

    // random board updates mid-frame
    for (int f = 0; f < 10; f++) begin
      wait_pix(0, 5, ok);
      cells        = 18'($urandom);
      cursor_en    = ($urandom % 4) != 0;
      cursor_x     = 4'($urandom_range(0, 4));
      cursor_y     = 4'($urandom_range(0, 3));
      if ($urandom % 5 == 0) cursor_x = 4'd7;
      overlay_lose = ($urandom % 3) == 0;
    end
    wait_pix(0, VT - 1, ok);
    wait_pix(0, VT - 1, ok);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
